// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory request/response port.
package dmem_pkg;

   localparam int DMEM_WORDW = 32;
   localparam int DMEM_BEW   = 4;
   localparam int DMEM_TAGW  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   typedef struct packed {
      logic                  we;
      logic [31:0]           addr;
      logic [DMEM_WORDW-1:0] wdata;
      logic [DMEM_BEW-1:0]   be;
      logic [DMEM_TAGW-1:0]  tag;
   } dmem_req_t;

   typedef struct packed {
      logic [DMEM_WORDW-1:0] rdata;
      logic [DMEM_TAGW-1:0]  tag;
      logic                  we;
      logic                  err;
   } dmem_rsp_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 synchronous RAM: byte-enabled write port, registered read port.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [AW-1:0]         addr,
   input  logic [DMEM_WORDW-1:0] wdata,
   input  logic [DMEM_BEW-1:0]   be,
   output logic [DMEM_WORDW-1:0] rdata
);

   logic [DMEM_WORDW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < DMEM_BEW; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      // rdata holds its value between loads; the responder relies on this.
      if (rd_en) rdata <= mem[addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency.
// Optional out-of-range detection is built when DMEM_ERR_EN is defined.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2,
   parameter int TAGW    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [31:0]           req_addr,
   input  logic [DMEM_WORDW-1:0] req_wdata,
   input  logic [DMEM_BEW-1:0]   req_be,
   input  logic [TAGW-1:0]       req_tag,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DMEM_WORDW-1:0] rsp_rdata,
   output logic [TAGW-1:0]       rsp_tag,
   output logic                  rsp_we,
   output logic                  rsp_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   dmem_state_t           state;
   logic [3:0]            cnt;
   logic                  rd_sel;
   logic                  accept;
   logic                  addr_err;
   logic                  wr_en;
   logic                  rd_en;
   logic [AW-1:0]         word_idx;
   logic [DMEM_WORDW-1:0] rd_q;
   logic                  unused_addr_bits;

   assign word_idx         = req_addr[AW+1:2];
   assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:AW+2]};

`ifdef DMEM_ERR_EN
   assign addr_err = |req_addr[31:AW+2];
`else
   assign addr_err = 1'b0;
`endif

   assign accept = (state == IDLE) && req_valid;
   assign wr_en  = accept && req_we && !addr_err;
   assign rd_en  = accept && !req_we && !addr_err;

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .wr_en (wr_en),
      .rd_en (rd_en),
      .addr  (word_idx),
      .wdata (req_wdata),
      .be    (req_be),
      .rdata (rd_q)
   );

   // Stores and errored loads report zero; the RAM read register is not reset.
   assign rsp_rdata = rd_sel ? rd_q : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_tag   <= '0;
         rsp_we    <= 1'b0;
         rsp_err   <= 1'b0;
         rd_sel    <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  rsp_tag   <= req_tag;
                  rsp_we    <= req_we;
                  rsp_err   <= addr_err;
                  rd_sel    <= rd_en;
                  req_ready <= 1'b0;
                  if (LATENCY == 1) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                  end else begin
                     cnt   <= CNT_INIT;
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a scoreboard queue and a word model.
module tb_dmem_responder;

   localparam int DEPTH   = 1024;
   localparam int LATENCY = 2;
   localparam int TAGW    = 4;

   typedef struct {
      logic [31:0]     rdata;
      logic [TAGW-1:0] tag;
      logic            we;
      logic            err;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [31:0]     req_addr;
   logic [31:0]     req_wdata;
   logic [3:0]      req_be;
   logic [TAGW-1:0] req_tag;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [31:0]     rsp_rdata;
   logic [TAGW-1:0] rsp_tag;
   logic            rsp_we;
   logic            rsp_err;

   exp_t        sb_q[$];
   logic [31:0] model [int];
   int          n_checks = 0;
   int          n_fail   = 0;

   dmem_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY),
      .TAGW    (TAGW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .req_tag   (req_tag),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_tag   (rsp_tag),
      .rsp_we    (rsp_we),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic addr_is_err(input logic [31:0] a);
`ifdef DMEM_ERR_EN
      return |a[31:12];
`else
      return 1'b0;
`endif
   endfunction

   // Issue one request from IDLE, follow it through latency, hold and release.
   task automatic txn(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [TAGW-1:0] tag, input int hold);
      exp_t e;
      int   idx;
      logic err;
      idx = int'(addr[11:2]);
      err = addr_is_err(addr);
      chk({name, "_ready_idle"}, 32'(req_ready), 32'd1);
      e.tag = tag;
      e.we  = we;
      e.err = err;
      if (we) begin
         e.rdata = 32'h0;
         if (!err) begin
            logic [31:0] w;
            w = model.exists(idx) ? model[idx] : 32'h0;
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
            model[idx] = w;
         end
      end else begin
         e.rdata = err ? 32'h0 : model[idx];
      end
      sb_q.push_back(e);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      req_tag   = tag;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_wdata = 32'hFFFF_FFFF;
      req_tag   = ~tag;
      chk({name, "_ready_busy"}, 32'(req_ready), 32'd0);
      chk({name, "_valid_early"}, 32'(rsp_valid), (LATENCY == 1) ? 32'd1 : 32'd0);
      for (int k = 1; k < LATENCY; k++) begin
         @(posedge clk); #1;
         chk({name, "_valid_lat"}, 32'(rsp_valid), (k == LATENCY - 1) ? 32'd1 : 32'd0);
         chk({name, "_ready_lat"}, 32'(req_ready), 32'd0);
      end
      e = sb_q.pop_front();
      chk({name, "_rdata"}, rsp_rdata, e.rdata);
      chk({name, "_tag"}, 32'(rsp_tag), 32'(e.tag));
      chk({name, "_we"}, 32'(rsp_we), 32'(e.we));
      chk({name, "_err"}, 32'(rsp_err), 32'(e.err));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
         chk({name, "_hold_ready"}, 32'(req_ready), 32'd0);
         chk({name, "_hold_rdata"}, rsp_rdata, e.rdata);
         chk({name, "_hold_tag"}, 32'(rsp_tag), 32'(e.tag));
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk({name, "_done_valid"}, 32'(rsp_valid), 32'd0);
      chk({name, "_done_ready"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      req_tag   = '0;
      rsp_ready = 1'b1;
      #23;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
      chk("rst_rsp_we", 32'(rsp_we), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      rsp_ready = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      // rsp_ready is ignored while nothing is pending
      repeat (2) @(posedge clk);
      #1;
      chk("idle_ready_ignored", 32'(req_ready), 32'd1);

      txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 4'd3, 0);
      txn("ld10", 1'b0, 32'h10, 32'h0,        4'h0, 4'd5, 0);
      txn("ld13", 1'b0, 32'h13, 32'h0,        4'h0, 4'd6, 0);

      txn("st20a", 1'b1, 32'h20, 32'h11223344, 4'hF, 4'd1, 0);
      txn("st20b", 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 4'd2, 0);
      txn("ld20",  1'b0, 32'h20, 32'h0,        4'h0, 4'd7, 5);
      chk("merge_value", model[8], 32'h11BB33DD);
      txn("st20z", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 4'd8, 0);
      txn("ld20z", 1'b0, 32'h20, 32'h0,        4'h0, 4'd9, 0);

      // Reset while the store waits: write kept, no response.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h40;
      req_wdata = 32'hCAFEF00D;
      req_be    = 4'hF;
      req_tag   = 4'd10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      model[16] = 32'hCAFEF00D;
      rst = 1'b1;
      #1;
      chk("rstw_valid", 32'(rsp_valid), 32'd0);
      chk("rstw_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("rstw_no_rsp", 32'(rsp_valid), 32'd0);
      end
      txn("ld40", 1'b0, 32'h40, 32'h0, 4'h0, 4'd11, 0);

      // Out-of-range store: error build flags it, default build wraps to word 0.
      txn("st00", 1'b1, 32'h0,    32'h0BADF00D, 4'hF, 4'd12, 0);
      txn("st1k", 1'b1, 32'h1000, 32'h12345678, 4'hF, 4'd13, 0);
      txn("ld00", 1'b0, 32'h0,    32'h0,        4'h0, 4'd14, 0);
      txn("ld1k", 1'b0, 32'h1000, 32'h0,        4'h0, 4'd15, 1);

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
